// File: rtl/epRISC_io_pkg.sv
// Shared epRISC I/O definitions: scheduler state encoding, UART register map
// and control-register bit positions.
package epRISC_io_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_GRANT,
    ST_WR_DATA,
    ST_WR_CTRL,
    ST_GAP,
    ST_POLL
  } sched_state_e;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_DATA = 2'd1,
    REG_RECV = 2'd2
  } uart_reg_e;

  localparam int CTRL_SEND      = 7;
  localparam int CTRL_INTRECV   = 6;
  localparam int CTRL_ALLOWRECV = 5;

  // Control word: Send flag plus the caller's format/receive/interrupt bits.
  function automatic logic [15:0] ctrl_word(input logic send, input logic [6:0] cfg);
    ctrl_word                 = 16'h0000;
    ctrl_word[CTRL_SEND]      = send;
    ctrl_word[CTRL_INTRECV]   = cfg[CTRL_INTRECV];
    ctrl_word[CTRL_ALLOWRECV] = cfg[CTRL_ALLOWRECV];
    ctrl_word[4:0]            = cfg[4:0];
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first valid index searching upward from
// ptr+1, wrapping modulo NREQ.
module uart_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  // Walk offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (valid[(int'(ptr) + k) % NREQ]) begin
        winner = PW'((int'(ptr) + k) % NREQ);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler that owns the epRISC UART register bus.
// Optional poll timeout with error pulse: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import epRISC_io_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter int          POLL_GAP = 2,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic [6:0]        iCfg,
  input  logic [NREQ-1:0]   iReqValid,
  input  logic [8*NREQ-1:0] iReqData,
  output logic [NREQ-1:0]   oReqReady,
  output logic [1:0]        oUartAddr,
  output logic [15:0]       oUartData,
  input  logic [15:0]       iUartData,
  output logic              oUartWrite,
  output logic              oUartEnable,
  output logic              oBusy,
  output logic              oErr
);

  localparam int PW = $clog2(NREQ);

  sched_state_e  state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] winner;
  logic          any_valid;
  logic [3:0]    gap_cnt;
  logic [7:0]    win_byte;
  logic          unused_rd;

  uart_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid  (iReqValid),
    .ptr    (ptr),
    .winner (winner),
    .any    (any_valid)
  );

  assign win_byte  = iReqData[int'(winner)*8 +: 8];
  assign unused_rd = ^{iUartData[15:8], iUartData[6:0]};

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Accept strobe follows the live arbitration so a dropped valid is never acked.
  always_comb begin
    oReqReady = '0;
    if (state == ST_GRANT && any_valid) oReqReady[winner] = 1'b1;
  end

  // Bus outputs are registered: each transition loads the values for the next state.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state       <= ST_INIT;
      ptr         <= PW'(NREQ - 1);
      gap_cnt     <= 4'd0;
      oUartAddr   <= 2'd0;
      oUartData   <= 16'h0000;
      oUartWrite  <= 1'b0;
      oUartEnable <= 1'b0;
      oBusy       <= 1'b0;
      oErr        <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_cnt      <= 16'd0;
`endif
    end else begin
      oUartAddr   <= REG_CTRL;
      oUartData   <= 16'h0000;
      oUartWrite  <= 1'b0;
      oUartEnable <= 1'b0;
      oErr        <= 1'b0;
      oBusy       <= 1'b1;
      case (state)
        ST_INIT: begin
          gap_cnt <= 4'd0;
          state   <= ST_GAP;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          to_cnt  <= 16'd0;
`endif
        end
        ST_IDLE: begin
          if (iEn && any_valid) state <= ST_GRANT;
          else                  oBusy <= 1'b0;
        end
        ST_GRANT: begin
          if (any_valid) begin
            ptr         <= winner;
            state       <= ST_WR_DATA;
            oUartAddr   <= REG_DATA;
            oUartData   <= {8'h00, win_byte};
            oUartWrite  <= 1'b1;
            oUartEnable <= 1'b1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            to_cnt      <= 16'd0;
`endif
          end else begin
            state <= ST_IDLE;
            oBusy <= 1'b0;
          end
        end
        ST_WR_DATA: begin
          state       <= ST_WR_CTRL;
          oUartAddr   <= REG_CTRL;
          oUartData   <= ctrl_word(1'b1, iCfg);
          oUartWrite  <= 1'b1;
          oUartEnable <= 1'b1;
        end
        ST_WR_CTRL: begin
          gap_cnt <= 4'd0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == 4'(POLL_GAP - 1)) begin
            state       <= ST_POLL;
            oUartEnable <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        ST_POLL: begin
          if (iUartData[CTRL_SEND]) begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
            to_cnt <= to_cnt + 16'd1;
            // Give up: clear Send so the UART is released, report, and move on.
            if (to_cnt == TIMEOUT - 16'd1) begin
              state       <= ST_IDLE;
              oBusy       <= 1'b0;
              oErr        <= 1'b1;
              oUartAddr   <= REG_CTRL;
              oUartData   <= ctrl_word(1'b0, iCfg);
              oUartWrite  <= 1'b1;
              oUartEnable <= 1'b1;
            end else begin
              gap_cnt <= 4'd0;
              state   <= ST_GAP;
            end
`else
            gap_cnt <= 4'd0;
            state   <= ST_GAP;
`endif
          end else begin
            state <= ST_IDLE;
            oBusy <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus pushes expected UART writes and
// grants into queues; a negedge monitor pops and compares.
module tb_uart_tx_sched;

  localparam int NREQ  = 4;
  localparam int FRAME = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [6:0]        cfg;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ready;
  logic [1:0]        uaddr;
  logic [15:0]       uwdata;
  logic [15:0]       urdata;
  logic              uwrite;
  logic              uen;
  logic              busy;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_wr[$];
  int          exp_gnt[$];
  int          exp_err[$];

  int   uart_cnt  = 0;
  int   init_busy = 20;
  logic stuck     = 1'b0;
  bit   last_clear;
  int   busy_polls;

  always #5 clk = ~clk;

  uart_tx_sched #(.NREQ(NREQ), .POLL_GAP(2), .TIMEOUT(16'd16)) dut (
    .iClk        (clk),
    .iRst        (rst_n),
    .iEn         (en),
    .iCfg        (cfg),
    .iReqValid   (req_valid),
    .iReqData    (req_data),
    .oReqReady   (ready),
    .oUartAddr   (uaddr),
    .oUartData   (uwdata),
    .iUartData   (urdata),
    .oUartWrite  (uwrite),
    .oUartEnable (uen),
    .oBusy       (busy),
    .oErr        (err)
  );

  // UART model: Send stays set for FRAME cycles after a control write with bit 7.
  always @(posedge clk) begin
    if (!rst_n)                               uart_cnt <= init_busy;
    else if (uen && uwrite && uaddr == 2'd0)  uart_cnt <= uwdata[7] ? FRAME : 0;
    else if (uart_cnt != 0)                   uart_cnt <= uart_cnt - 1;
  end
  assign urdata = (uen && uaddr == 2'd0) ? {8'h00, (stuck || uart_cnt != 0), 7'h00} : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_missing(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_clear = 1'b0;
        busy_polls = 0;
      end else begin
        if (uen && !uwrite && uaddr == 2'd0) begin
          if (urdata[7]) busy_polls++;
          else begin
            last_clear = 1'b1;
            busy_polls = 0;
          end
        end
        if (!uen) check("bus_zero_when_disabled", {14'd0, uaddr, uwdata}, 32'd0);
        if (uen && uwrite) begin
          if (exp_wr.size() == 0) fail_missing("unexpected_write");
          else check("uart_write", {14'd0, uaddr, uwdata}, {14'd0, exp_wr.pop_front()});
        end
        if (|ready) begin
          check("ready_onehot", 32'($onehot(ready)), 32'd1);
          check("grant_after_clear_poll", 32'(last_clear), 32'd1);
          if (exp_gnt.size() == 0) fail_missing("unexpected_grant");
          else check("grant_index", idx_of(ready), exp_gnt.pop_front());
          last_clear = 1'b0;
          busy_polls = 0;
        end
        if (err) begin
          if (exp_err.size() == 0) fail_missing("unexpected_err");
          else check("err_after_busy_polls", busy_polls, exp_err.pop_front());
          last_clear = 1'b1;
        end
      end
    end
  end

  task automatic expect_byte(input int idx, input logic [7:0] b);
    exp_gnt.push_back(idx);
    exp_wr.push_back({2'd1, 8'h00, b});
    exp_wr.push_back({2'd0, 16'h0083});
  endtask

  // Drops each accepted valid right after its GRANT edge; optionally re-raises one.
  task automatic wait_grants(input int n, input int reload_idx, input logic [7:0] reload_byte);
    int got = 0;
    bit done = (reload_idx < 0);
    logic [NREQ-1:0] m;
    for (int c = 0; c < 3000 && got < n; c++) begin
      @(negedge clk);
      if (|ready) begin
        m = ready;
        got++;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~m;
        if (!done && m[reload_idx]) begin
          req_data[reload_idx*8 +: 8] = reload_byte;
          req_valid[reload_idx] = 1'b1;
          done = 1'b1;
        end
      end
    end
    check("grant_count", got, n);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    cfg       = 7'h03;
    req_valid = '0;
    req_data  = '0;
    #1;
    check("reset_outputs", {6'd0, ready, uaddr, uwdata, uwrite, uen, busy, err}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("busy_during_init", 32'(busy), 32'd1);
    check("no_ready_during_init", 32'(ready), 32'd0);

    // All four valid from ptr=3; req0 re-raised after its first grant.
    expect_byte(0, 8'h10);
    expect_byte(1, 8'h11);
    expect_byte(2, 8'h12);
    expect_byte(3, 8'h13);
    expect_byte(0, 8'h14);
    req_data  = 32'h13121110;
    req_valid = 4'hF;
    wait_grants(5, 0, 8'h14);

    // Single requester 2: data write then control write on the next cycle.
    expect_byte(2, 8'h41);
    req_data[23:16] = 8'h41;
    req_valid[2]    = 1'b1;
    wait_grants(1, -1, 8'h00);
    check("req2_data_write", {13'd0, uwrite, uaddr, uwdata}, {13'd0, 1'b1, 2'd1, 16'h0041});
    @(posedge clk);
    #1;
    check("req2_ctrl_write", {13'd0, uwrite, uaddr, uwdata}, {13'd0, 1'b1, 2'd0, 16'h0083});

    // Enable dropped during GAP: current byte finishes, req1 waits.
    expect_byte(0, 8'h20);
    req_data[7:0] = 8'h20;
    req_valid[0]  = 1'b1;
    wait_grants(1, -1, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    en             = 1'b0;
    req_data[15:8] = 8'h21;
    req_valid[1]   = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("idle_while_disabled_busy", 32'(busy), 32'd0);
    check("idle_while_disabled_ready", 32'(ready), 32'd0);
    expect_byte(1, 8'h21);
    en = 1'b1;
    wait_grants(1, -1, 8'h00);

    // Async reset while the control write is on the bus.
    exp_gnt.push_back(3);
    exp_wr.push_back({2'd1, 16'h0033});
    req_data[31:24] = 8'h33;
    req_valid[3]    = 1'b1;
    wait_grants(1, -1, 8'h00);
    @(posedge clk);
    #1;
    check("in_wr_ctrl", {13'd0, uwrite, uaddr, uwdata}, {13'd0, 1'b1, 2'd0, 16'h0083});
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {6'd0, ready, uaddr, uwdata, uwrite, uen, busy, err}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_byte(1, 8'h51);
    req_data[15:8] = 8'h51;
    req_valid[1]   = 1'b1;
    wait_grants(1, -1, 8'h00);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // UART stuck busy: abort after 16 busy polls, Send dropped, next requester served.
    stuck = 1'b1;
    exp_gnt.push_back(2);
    exp_wr.push_back({2'd1, 16'h0077});
    exp_wr.push_back({2'd0, 16'h0083});
    exp_wr.push_back({2'd0, 16'h0003});
    exp_err.push_back(16);
    req_data[23:16] = 8'h77;
    req_valid[2]    = 1'b1;
    wait_grants(1, -1, 8'h00);
    for (int c = 0; c < 400 && exp_err.size() != 0; c++) @(negedge clk);
    check("timeout_err_seen", exp_err.size(), 0);
    stuck = 1'b0;
    expect_byte(3, 8'h78);
    req_data[31:24] = 8'h78;
    req_valid[3]    = 1'b1;
    wait_grants(1, -1, 8'h00);
`endif

    for (int c = 0; c < 300 && (exp_wr.size() != 0 || exp_gnt.size() != 0); c++) @(negedge clk);
    check("writes_drained", exp_wr.size(), 0);
    check("grants_drained", exp_gnt.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin transmit scheduler sharing one epRISC UART among NREQ byte producers (CPU console, debug monitor, DMA).
- Sits between the producers and the UART's 2-bit-address register bus. It writes each byte to the UART data register (addr 1), sets Send (control bit 7), then polls control until bit 7 clears before granting the next producer.
- The block is the only master of the UART bus while enabled.

Parameters:
- NREQ, 4, number of requesters (2..8).
- POLL_GAP, 2, idle cycles between consecutive status reads (1..15).
- TIMEOUT, 16'hFFFF, poll cycles before abort (TIMEOUT_EN only).

Ports:
- iClk  in  1  system clock; same clock as the UART register side.
- iRst  in  1  reset, asynchronous assert, active-low (0 = reset).
- iEn  in  1  scheduler enable; 0 = finish the current byte, then stop granting.
- iCfg  in  7  UART control bits 6:0 (bits/stop/parity/recv/int) merged into every control write.
- iReqValid  in  NREQ  per-requester byte valid; held until accepted.
- iReqData  in  8*NREQ  per-requester byte; slice i = bits 8i+7:8i.
- oReqReady  out  NREQ  one-hot accept strobe, one cycle.
- oUartAddr  out  2  UART register address.
- oUartData  out  16  UART write data.
- iUartData  in  16  UART read data, combinational for the current address.
- oUartWrite  out  1  UART write strobe.
- oUartEnable  out  1  UART chip enable.
- oBusy  out  1  high in any state except IDLE.
- oErr  out  1  one-cycle timeout pulse; constant 0 without TIMEOUT_EN.

Behaviour:
- Reset values: all outputs 0; state INIT; rr pointer = NREQ-1; captured byte 0; gap and timeout counters 0.
- States: INIT, IDLE, GRANT, WR_DATA, WR_CTRL, GAP, POLL.
- INIT: after reset the UART may still be shifting. Go to GAP then POLL; when bit 7 reads clear, go to IDLE. No grant happens before this.
- IDLE: if iEn and any iReqValid, go to GRANT. Winner = first valid index searching upward from ptr+1 modulo NREQ.
- GRANT (1 cycle): assert oReqReady[winner]; capture iReqData slice; ptr <= winner. The winner is recomputed in this cycle. If its valid dropped (protocol violation), do not accept and return to IDLE.
- WR_DATA (1 cycle): Addr=1, Data={8'h00,byte}, Write=1, Enable=1.
- WR_CTRL (1 cycle): Addr=0, Data={8'h00,1'b1,iCfg}, Write=1, Enable=1.
- GAP: count POLL_GAP cycles with Enable=0, then go to POLL.
- POLL (1 cycle): Addr=0, Enable=1, Write=0; sample iUartData[7].
  - If 1, go back to GAP.
  - If 0: from INIT go to IDLE; otherwise go to IDLE (new arbitration next cycle).
- Minimum byte-to-byte scheduler overhead = 4 + POLL_GAP cycles plus the UART frame time.
- Fairness: a requester holding valid continuously is served at most once per NREQ grants when all requesters are valid.
- iEn falling mid-transfer: the current byte completes through POLL; IDLE then holds.
- Simultaneous valids: only the rr winner gets ready; the others hold.
- ptr wrap: NREQ-1 -> 0.
- Reset mid-transfer: outputs go 0 immediately (async); resume in INIT, so a frame still being sent is never overwritten.
- oUartData = 0 and oUartAddr = 0 whenever oUartEnable = 0.

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments on each POLL that returns bit 7 = 1 and clears on entry to WR_DATA/INIT.
  - On reaching TIMEOUT: pulse oErr one cycle and write control = {8'h00,1'b0,iCfg} (drop Send), then go to IDLE.
  - The byte is lost and ptr still advances.
- Undefined: no counter; oErr tied 0; polling is unbounded.

Decomposition:
- Shared package epRISC_io_pkg:
  - state encoding constants;
  - UART register addresses (CTRL=0, DATA=1, RECV=2);
  - control bit positions (SEND=7, INTRECV=6, ALLOWRECV=5).
- One sub-module: uart_rr_arbiter. Pure combinational round-robin picker: valid vector + ptr -> winner index + any.

Test Plan:
- Reset release; UART model reports bit7=1 for 20 cycles -> no oReqReady before the first POLL reads 0; oBusy=1 throughout INIT.
- Req2 valid with 8'h41, iCfg=7'h03 -> write addr1 data 16'h0041, next cycle write addr0 data 16'h0083, oReqReady[2] pulsed once.
- All four valid, bytes 8'h10..8'h13, ptr=3 -> grant order 0,1,2,3,0; each grant occurs only after the prior POLL read bit7=0.
- iEn dropped during GAP with req1 pending -> current byte's POLL completes, returns to IDLE, req1 never granted until iEn=1.
- Async reset asserted in WR_CTRL -> all outputs 0 within the same cycle; after release, INIT polls before any grant.
- TIMEOUT_EN, TIMEOUT=16, UART stuck busy -> oErr pulse after 16 busy polls; control written 16'h00XX with bit7=0; next requester granted.
